register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 62 ++++++
 tb/tb_register_file.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Two-read, one-write register file with x0 hard-wired to zero and a saturating write counter.
// Optional macro REGFILE_BYPASS_EN enables write-first forwarding from the write port to the read ports.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [15:0]       wr_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [15:0]       r_wr_count;
    logic              w_commit;

    assign w_commit = wr_en && (wr_addr != '0);

    // NOTE: the array sits in flops rather than RAM because reset must clear every entry
    // asynchronously; a RAM macro cannot do that, so do not remap this to a memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_regs[wr_addr] <= wr_data;
            if (r_wr_count != 16'hFFFF) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    // NOTE: each output takes its stored value first, so every path assigns it and no latch forms.
    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        // w_commit already excludes x0; rst_n gates forwarding while the array is held clear.
        if (rst_n && w_commit && (rs1_addr == wr_addr)) begin
            rs1_data = wr_data;
        end
        if (rst_n && w_commit && (rs2_addr == wr_addr)) begin
            rs2_data = wr_data;
        end
`else
        // Read-first: the stored value stays visible until the committing edge.
`endif
    end

    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expected values are hand-computed constants.
// Same-cycle expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives one write at a falling edge; it commits at the following rising edge.
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Holds wr_en for exactly n rising edges.
    task automatic write_burst(input int n, input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        repeat (n) @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        // Reset state
        set_reads(5'd5, 5'd31);
        check("reset_rs1_x5", rs1_data, 32'h0);
        check("reset_rs2_x31", rs2_data, 32'h0);
        check("reset_count", 32'(wr_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read
        write_reg(5'd5, 32'h001142B3);
        write_reg(5'd6, 32'hA1B2C3D4);
        set_reads(5'd5, 5'd6);
        check("basic_rs1_x5", rs1_data, 32'h001142B3);
        check("basic_rs2_x6", rs2_data, 32'hA1B2C3D4);
        check("basic_count", 32'(wr_count), 32'd2);

        // x0 guard
        write_reg(5'd0, 32'hFFFFFFFF);
        set_reads(5'd0, 5'd0);
        check("x0_read", rs1_data, 32'h0);
        check("x0_count", 32'(wr_count), 32'd2);

        // Same-cycle read of the write target, and a pending x0 write seen on port 2
        @(negedge clk);
        set_reads(5'd7, 5'd0);
        check("x7_initial", rs1_data, 32'h0);
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'hDEADBEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x7_before_edge", rs1_data, 32'hDEADBEEF);
`else
        check("x7_before_edge", rs1_data, 32'h0);
`endif
        check("x0_port2_during_wr", rs2_data, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("x7_after_edge", rs1_data, 32'hDEADBEEF);
        check("x7_count", 32'(wr_count), 32'd3);

        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'h12345678;
        set_reads(5'd0, 5'd0);
        check("x0_no_bypass", rs1_data, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("x0_no_bypass_count", 32'(wr_count), 32'd3);

        // Dual-port alias and idle stability
        set_reads(5'd6, 5'd6);
        check("alias_rs1", rs1_data, 32'hA1B2C3D4);
        check("alias_rs2", rs2_data, 32'hA1B2C3D4);
        wr_addr = 5'd5;
        wr_data = 32'h0BADF00D;
        repeat (10) @(negedge clk);
        set_reads(5'd5, 5'd7);
        check("idle_x5", rs1_data, 32'h001142B3);
        check("idle_x7", rs2_data, 32'hDEADBEEF);
        check("idle_count", 32'(wr_count), 32'd3);

        // Back-to-back writes to one index
        write_burst(1, 5'd9, 32'h00001111);
        write_reg(5'd9, 32'h00002222);
        set_reads(5'd9, 5'd6);
        check("b2b_x9", rs1_data, 32'h00002222);
        check("b2b_count", 32'(wr_count), 32'd5);

        // Mid-cycle asynchronous reset, write ignored during reset, first write after release
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        set_reads(5'd5, 5'd7);
        check("rst_mid_x5", rs1_data, 32'h0);
        check("rst_mid_x7", rs2_data, 32'h0);
        check("rst_mid_count", 32'(wr_count), 32'h0);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h55AA55AA;
        #1;
        check("rst_no_bypass", rs1_data, 32'h0);
        @(negedge clk);
        check("rst_wr_lost_x5", rs1_data, 32'h0);
        check("rst_wr_lost_count", 32'(wr_count), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("post_rst_x5", rs1_data, 32'h55AA55AA);
        check("post_rst_count", 32'(wr_count), 32'd1);

        // Saturation from a clean reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        write_burst(65534, 5'd1, 32'hCAFE0001);
        #1;
        check("sat_fffe", 32'(wr_count), 32'h0000FFFE);
        write_burst(1, 5'd1, 32'hCAFE0002);
        #1;
        check("sat_ffff", 32'(wr_count), 32'h0000FFFF);
        write_burst(1, 5'd1, 32'hCAFE0003);
        #1;
        check("sat_65536", 32'(wr_count), 32'h0000FFFF);
        write_burst(1, 5'd1, 32'hCAFE0004);
        set_reads(5'd1, 5'd0);
        check("sat_hold", 32'(wr_count), 32'h0000FFFF);
        check("sat_last_data", rs1_data, 32'hCAFE0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
